// File: rtl/pipelined_ilm_mult.sv
// Three-stage pipelined improved logarithmic multiplier for sign-magnitude operands,
// with per-transaction choice of basic or one-iteration corrected ILM.
module pipelined_ilm_mult #(
    parameter int unsigned WIDTH   = 8,
    parameter bit          CORR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH:0]     in_a,
    input  logic [WIDTH:0]     in_b,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_exact
);

    localparam int unsigned KW = $clog2(WIDTH);
    localparam int unsigned QW = WIDTH + 1;
    localparam int unsigned PW = 2*WIDTH + 2;
    localparam int unsigned OW = 2*WIDTH;

    // Nearest power-of-two exponent: leading one, bumped when the next bit is set (ties up), capped.
    function automatic logic [KW-1:0] near_k(input logic [WIDTH-1:0] m);
        logic [KW-1:0] k;
        k = '0;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            if (m[i]) k = (m[i-1] && (i < WIDTH-1)) ? KW'(i + 1) : KW'(i);
        end
        return k;
    endfunction

    function automatic logic signed [QW-1:0] resid(input logic [WIDTH-1:0] m,
                                                    input logic [KW-1:0]    k);
        return $signed({1'b0, m}) - $signed(QW'(1) << k);
    endfunction

    // 2^(k1+k2) + q1*2^k2 + q2*2^k1, signed
    function automatic logic signed [PW-1:0] ilm(input logic [KW-1:0]        k1,
                                                  input logic [KW-1:0]        k2,
                                                  input logic signed [QW-1:0] q1,
                                                  input logic signed [QW-1:0] q2);
        logic signed [PW-1:0] e1;
        logic signed [PW-1:0] e2;
        logic [KW:0]          ks;
        e1 = PW'(q1);
        e2 = PW'(q2);
        ks = (KW+1)'(k1) + (KW+1)'(k2);
        return $signed(PW'(1) << ks) + (e1 <<< k2) + (e2 <<< k1);
    endfunction

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // stage 1 combinational: decompose operands
    logic [WIDTH-1:0]        a_mag, b_mag;
    logic [KW-1:0]           a_k, b_k;
    logic signed [QW-1:0]    a_q, b_q;

    always_comb begin
        a_mag = in_a[WIDTH-1:0];
        b_mag = in_b[WIDTH-1:0];
        a_k   = near_k(a_mag);
        b_k   = near_k(b_mag);
        a_q   = resid(a_mag, a_k);
        b_q   = resid(b_mag, b_k);
    end

    logic                 s1_v, s1_z, s1_mode, s1_sign;
    logic [KW-1:0]        s1_k1, s1_k2;
    logic signed [QW-1:0] s1_q1, s1_q2;

    // stage 2 combinational: basic product and correction decomposition of |q|
    logic signed [PW-1:0] p0;
    logic [WIDTH-1:0]     q1_abs, q2_abs;
    logic [KW-1:0]        c_k1, c_k2;
    logic signed [QW-1:0] c_r1, c_r2;

    always_comb begin
        p0     = ilm(s1_k1, s1_k2, s1_q1, s1_q2);
        q1_abs = WIDTH'(s1_q1[QW-1] ? -s1_q1 : s1_q1);
        q2_abs = WIDTH'(s1_q2[QW-1] ? -s1_q2 : s1_q2);
        c_k1   = near_k(q1_abs);
        c_k2   = near_k(q2_abs);
        c_r1   = resid(q1_abs, c_k1);
        c_r2   = resid(q2_abs, c_k2);
    end

    logic                 s2_v, s2_z, s2_mode, s2_sign, s2_qz, s2_neg;
    logic signed [PW-1:0] s2_p0;
    logic [KW-1:0]        s2_k1, s2_k2;
    logic signed [QW-1:0] s2_r1, s2_r2;

    // stage 3 combinational: apply signed correction when q1*q2 != 0
    logic signed [PW-1:0] corr;
    logic [OW-1:0]        p_fin;
    logic                 exact;

    always_comb begin
        corr  = ilm(s2_k1, s2_k2, s2_r1, s2_r2);
        p_fin = OW'(s2_p0);
        if (s2_mode && !s2_qz) p_fin = s2_neg ? OW'(s2_p0 - corr) : OW'(s2_p0 + corr);
        exact = s2_z | s2_qz | (s2_mode & ((s2_r1 == '0) | (s2_r2 == '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s1_z <= 1'b0; s1_mode <= 1'b0; s1_sign <= 1'b0;
            s1_k1 <= '0; s1_k2 <= '0; s1_q1 <= '0; s1_q2 <= '0;
            s2_v <= 1'b0; s2_z <= 1'b0; s2_mode <= 1'b0; s2_sign <= 1'b0;
            s2_qz <= 1'b0; s2_neg <= 1'b0; s2_p0 <= '0;
            s2_k1 <= '0; s2_k2 <= '0; s2_r1 <= '0; s2_r2 <= '0;
            out_valid <= 1'b0; out_sign <= 1'b0; out_product <= '0; out_exact <= 1'b0;
        end else if (adv) begin
            s1_v    <= in_valid;
            s1_z    <= (a_mag == '0) | (b_mag == '0);
            s1_mode <= in_mode & CORR_EN;
            s1_sign <= in_a[WIDTH] ^ in_b[WIDTH];
            s1_k1   <= a_k;
            s1_k2   <= b_k;
            s1_q1   <= a_q;
            s1_q2   <= b_q;

            s2_v    <= s1_v;
            s2_z    <= s1_z;
            s2_mode <= s1_mode;
            s2_sign <= s1_sign;
            s2_qz   <= (s1_q1 == '0) | (s1_q2 == '0);
            s2_neg  <= s1_q1[QW-1] ^ s1_q2[QW-1];
            s2_p0   <= p0;
            s2_k1   <= c_k1;
            s2_k2   <= c_k2;
            s2_r1   <= c_r1;
            s2_r2   <= c_r2;

            out_valid   <= s2_v;
            out_sign    <= s2_sign & ~s2_z;
            out_product <= s2_z ? '0 : p_fin;
            out_exact   <= exact;
        end
    end

endmodule

// File: tb/tb_pipelined_ilm_mult.sv
// Self-checking bench for pipelined_ilm_mult: directed literals, stall/flow-control,
// async reset flush, CORR_EN=0 variant and an exhaustive WIDTH=4 sweep against a model.
module tb_pipelined_ilm_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_sign8, out_exact8;
    logic [8:0]  in_a8, in_b8;
    logic [15:0] out_product8;
    logic        in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_sign4, out_exact4;
    logic [4:0]  in_a4, in_b4;
    logic [7:0]  out_product4;
    logic        in_validn, in_readyn, in_moden, out_validn, out_readyn, out_signn, out_exactn;
    logic [8:0]  in_an, in_bn;
    logic [15:0] out_productn;

    pipelined_ilm_mult #(.WIDTH(8), .CORR_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_mode(in_mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_sign(out_sign8), .out_product(out_product8),
        .out_exact(out_exact8));

    pipelined_ilm_mult #(.WIDTH(4), .CORR_EN(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_mode(in_mode4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_sign(out_sign4), .out_product(out_product4),
        .out_exact(out_exact4));

    pipelined_ilm_mult #(.WIDTH(8), .CORR_EN(1'b0)) dutn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_validn), .in_ready(in_readyn),
        .in_a(in_an), .in_b(in_bn), .in_mode(in_moden), .out_valid(out_validn),
        .out_ready(out_readyn), .out_sign(out_signn), .out_product(out_productn),
        .out_exact(out_exactn));

    typedef struct {
        bit     s;
        longint p;
        bit     e;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t qn[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out8 = 0;

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Nearest power of two by exhaustive distance search over allowed exponents
    function automatic int near_k(input int w, input longint m);
        int     k;
        longint bd;
        longint d;
        k  = 0;
        bd = -1;
        for (int i = 0; i < w; i++) begin
            d = m - (longint'(1) << i);
            if (d < 0) d = -d;
            if (bd < 0 || d <= bd) begin
                bd = d;
                k  = i;
            end
        end
        return k;
    endfunction

    function automatic longint ilm(input int w, input longint m1, input longint m2);
        int     k1;
        int     k2;
        longint q1;
        longint q2;
        k1 = near_k(w, m1);
        k2 = near_k(w, m2);
        q1 = m1 - (longint'(1) << k1);
        q2 = m2 - (longint'(1) << k2);
        return (longint'(1) << (k1 + k2)) + q1 * (longint'(1) << k2) + q2 * (longint'(1) << k1);
    endfunction

    function automatic exp_t model(input int w, input bit as, input longint ma,
                                   input bit bs, input longint mb, input bit mode, input bit corr);
        exp_t   r;
        longint q1;
        longint q2;
        if (ma == 0 || mb == 0) begin
            r.s = 1'b0; r.p = 0; r.e = 1'b1;
            return r;
        end
        r.p = ilm(w, ma, mb);
        q1  = ma - (longint'(1) << near_k(w, ma));
        q2  = mb - (longint'(1) << near_k(w, mb));
        if (mode && corr && q1 != 0 && q2 != 0) begin
            if ((q1 < 0) != (q2 < 0)) r.p = r.p - ilm(w, q1 < 0 ? -q1 : q1, q2 < 0 ? -q2 : q2);
            else                      r.p = r.p + ilm(w, q1 < 0 ? -q1 : q1, q2 < 0 ? -q2 : q2);
        end
        r.s = as ^ bs;
        r.e = (r.p == ma * mb);
        return r;
    endfunction

    // Scoreboards: push on accepted input, compare on consumed output, check hold under stall
    bit          stall8 = 1'b0;
    logic [15:0] hp8;
    logic        hs8, he8;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            q8.delete(); q4.delete(); qn.delete();
            stall8 = 1'b0;
        end else begin
            if (in_valid8 && in_ready8)
                q8.push_back(model(8, in_a8[8], longint'(in_a8[7:0]), in_b8[8], longint'(in_b8[7:0]), in_mode8, 1'b1));
            if (in_valid4 && in_ready4)
                q4.push_back(model(4, in_a4[4], longint'(in_a4[3:0]), in_b4[4], longint'(in_b4[3:0]), in_mode4, 1'b1));
            if (in_validn && in_readyn)
                qn.push_back(model(8, in_an[8], longint'(in_an[7:0]), in_bn[8], longint'(in_bn[7:0]), in_moden, 1'b0));
            if (stall8) begin
                chk("hold_valid", out_valid8, 1);
                chk("hold_product", out_product8, hp8);
                chk("hold_flags", {out_sign8, out_exact8}, {hs8, he8});
            end
            stall8 = out_valid8 && !out_ready8;
            hp8 = out_product8; hs8 = out_sign8; he8 = out_exact8;
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) chk("w8_unexpected_output", 1, 0);
                else begin
                    e = q8.pop_front();
                    n_out8++;
                    chk("w8_product", out_product8, e.p);
                    chk("w8_sign", out_sign8, e.s);
                    chk("w8_exact", out_exact8, e.e);
                end
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) chk("w4_unexpected_output", 1, 0);
                else begin
                    e = q4.pop_front();
                    chk("w4_product", out_product4, e.p);
                    chk("w4_sign", out_sign4, e.s);
                    chk("w4_exact", out_exact4, e.e);
                end
            end
            if (out_validn && out_readyn) begin
                if (qn.size() == 0) chk("nc_unexpected_output", 1, 0);
                else begin
                    e = qn.pop_front();
                    chk("nc_product", out_productn, e.p);
                    chk("nc_sign", out_signn, e.s);
                    chk("nc_exact", out_exactn, e.e);
                end
            end
        end
    end

    task automatic send8(input bit as, input int ma, input bit bs, input int mb, input bit mode);
        bit ok;
        in_a8 = {as, 8'(ma)};
        in_b8 = {bs, 8'(mb)};
        in_mode8 = mode;
        in_valid8 = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    // One transaction with out_ready high; result must appear on the third cycle after acceptance
    task automatic lit8(input string name, input bit as, input int ma, input bit bs, input int mb,
                        input bit mode, input longint ep, input bit es, input bit ee);
        send8(as, ma, bs, mb, mode);
        @(posedge clk); #1;
        chk({name, "_early"}, out_valid8, 0);
        @(posedge clk); #1;
        chk({name, "_valid"}, out_valid8, 1);
        chk({name, "_product"}, out_product8, ep);
        chk({name, "_sign"}, out_sign8, es);
        chk({name, "_exact"}, out_exact8, ee);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40; n++) begin
            if (q8.size() == 0 && q4.size() == 0 && qn.size() == 0) break;
            @(posedge clk); #1;
        end
        chk({name, "_drained"}, q8.size() + q4.size() + qn.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        exp_t m;
        int   base;
        in_valid8 = 0; in_a8 = '0; in_b8 = '0; in_mode8 = 0; out_ready8 = 1;
        in_valid4 = 0; in_a4 = '0; in_b4 = '0; in_mode4 = 0; out_ready4 = 1;
        in_validn = 0; in_an = '0; in_bn = '0; in_moden = 0; out_readyn = 1;

        // Pin the model against hand-computed values
        m = model(8, 0, 3, 0, 3, 0, 1);     chk("model_3x3_m0", m.p, 8);
        m = model(8, 0, 3, 0, 3, 1, 1);     chk("model_3x3_m1", m.p, 9);
        m = model(8, 0, 255, 1, 255, 1, 1); chk("model_255_m1", m.p, 65024);
        m = model(8, 0, 3, 0, 3, 1, 0);     chk("model_nocorr", m.p, 8);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_out_product", out_product8, 0);
        chk("rst_out_flags", {out_sign8, out_exact8}, 0);
        chk("rst_in_ready", in_ready8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        lit8("a3b3_m0",   0, 3,   0, 3,   0, 8,     0, 0);
        lit8("a3b3_m1",   0, 3,   0, 3,   1, 9,     0, 1);
        lit8("a255_m0",   0, 255, 1, 255, 0, 48896, 1, 0);
        lit8("a255_m1",   0, 255, 1, 255, 1, 65024, 1, 0);
        lit8("negzero_m0", 1, 0,  0, 200, 0, 0,     0, 1);
        lit8("negzero_m1", 1, 0,  0, 200, 1, 0,     0, 1);
        lit8("a64b32_m0", 0, 64,  1, 32,  0, 2048,  1, 1);

        // Back-to-back stream with the consumer stalled for four cycles
        base = n_out8;
        out_ready8 = 1'b0;
        fork
            begin
                send8(0, 3, 0, 3, 0);
                send8(0, 3, 0, 3, 1);
                send8(0, 255, 0, 255, 0);
                send8(0, 0, 0, 7, 0);
                send8(0, 64, 0, 32, 0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (out_valid8) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("stream_first_valid", seen, 1);
                for (int i = 0; i < 4; i++) begin
                    chk("stall_in_ready", in_ready8, 0);
                    chk("stall_product", out_product8, 8);
                    if (i < 3) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready8 = 1'b1;
            end
        join
        drain("stream");
        chk("stream_count", n_out8 - base, 5);

        // Async reset with three transactions in flight
        send8(0, 5, 0, 6, 0);
        send8(0, 7, 1, 9, 1);
        send8(0, 100, 0, 3, 0);
        send8(1, 17, 0, 33, 1);
        #2;
        chk("pre_reset_valid", out_valid8, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid8, 0);
        chk("async_rst_product", out_product8, 0);
        chk("async_rst_in_ready", in_ready8, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lit8("post_reset", 0, 12, 1, 10, 1, 120, 1, 1);
        drain("post_reset");

        // CORR_EN=0 variant: mode is ignored
        in_an = {1'b0, 8'd3}; in_bn = {1'b0, 8'd3}; in_moden = 1'b1; in_validn = 1'b1;
        @(posedge clk); #1;
        in_validn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("nc_valid", out_validn, 1);
        chk("nc_3x3_m1_product", out_productn, 8);
        chk("nc_3x3_m1_exact", out_exactn, 0);
        for (int i = 0; i < 6; i++) begin
            in_an = {1'(i), 8'(37 * i + 11)};
            in_bn = {1'(i >> 1), 8'(255 - 19 * i)};
            in_moden = 1'b1;
            in_validn = 1'b1;
            @(posedge clk); #1;
        end
        in_validn = 1'b0;
        drain("nocorr");

        // Exhaustive WIDTH=4 sweep, every sign/magnitude pair in both modes
        for (int md = 0; md < 2; md++)
            for (int a = 0; a < 32; a++)
                for (int b = 0; b < 32; b++) begin
                    in_a4 = 5'(a); in_b4 = 5'(b); in_mode4 = 1'(md); in_valid4 = 1'b1;
                    @(posedge clk); #1;
                end
        in_valid4 = 1'b0;
        drain("w4_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
